sys_arr_feeder: RTL and testbench

- Upstream stage of the systolic array: buffers and skews activation vectors into the left edge of a stack of systolic rows.
- Accepts one column vector per cycle over a valid/ready handshake, one signed 8-bit element per row.
- Delays row r by r cycles to form the diagonal wavefront, and drives each row's datain and active inputs.
- Frames each tile with a start command, then flushes zeros so partial sums drain, and signals done.

---
 rtl/sys_arr_feeder.sv | 149 ++++++++++++++
 tb/tb_sys_arr_feeder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/sys_arr_feeder.sv
// sys_arr_feeder
//   Upstream stage of the systolic array. Accepts one column vector per beat
//   (one signed 8-bit element per row), skews row r by r cycles so the array
//   sees a diagonal wavefront, frames each tile with a start command, then
//   feeds zeros for long enough that every partial sum drains out of the
//   array before signalling done.
//
// Ports
//   clk         system clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   start       begin a tile; sampled only while idle
//   vec_len     number of vectors in the tile; sampled with start
//   in_valid    in_data beat valid
//   in_data     packed elements, row r in bits [8r+7:8r]
//   in_ready    feeder accepts a beat this cycle
//   data_out    per-row datain to the array, same packing as in_data
//   active_out  per-row active flag to the array
//   busy        tile in progress (state != IDLE)
//   done        one-cycle tile-complete pulse
//   dbg_state   current FSM state (0 idle, 1 stream, 2 drain)
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on the FSM state (high exactly in STREAM), never on
// in_valid, so the producer may hold in_valid high for as long as it likes and
// may drop it at any time without penalty (no timeout).

module sys_arr_feeder #(
  parameter int NUM_ROWS  = 2,
  parameter int ROW_WIDTH = 2,
  parameter int LEN_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_W-1:0]      vec_len,
  input  logic                  in_valid,
  input  logic [8*NUM_ROWS-1:0] in_data,
  output logic                  in_ready,
  output logic [8*NUM_ROWS-1:0] data_out,
  output logic [NUM_ROWS-1:0]   active_out,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state
);

  // Zero-fill cycles needed after the last beat: the skew adds NUM_ROWS-1
  // cycles to the bottom row and the row itself is ROW_WIDTH PEs deep.
  localparam int D  = NUM_ROWS - 1 + ROW_WIDTH;
  localparam int DW = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  state_e           state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count_q;
  logic [DW-1:0]    drain_q;
  logic             done_q;
  logic             accept;

  assign in_ready  = (state_q == STREAM);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

  // Tile control FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      count_q <= '0;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (vec_len != '0) begin
              state_q <= STREAM;
              len_q   <= vec_len;
              count_q <= '0;
            end else begin
              // Empty tile: nothing to stream or drain, just acknowledge.
              done_q <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            count_q <= count_q + LEN_W'(1);
            if (count_q == len_q - LEN_W'(1)) begin
              state_q <= DRAIN;
              drain_q <= '0;
            end
          end
        end
        DRAIN: begin
          if (drain_q == DW'(D - 1)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + DW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Skew pipeline: row r holds r+1 stages followed by the output register,
  // so row r's element reaches data_out r+1 edges after the accepting edge.
  // Non-accept cycles shift in 0 / inactive, which keeps every bubble in the
  // same diagonal slot on all rows and flushes zeros during DRAIN.
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    logic [7:0] dat_q [r+1];
    logic       act_q [r+1];
    logic [7:0] out_dat_q;
    logic       out_act_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= r; s++) begin
          dat_q[s] <= '0;
          act_q[s] <= 1'b0;
        end
        out_dat_q <= '0;
        out_act_q <= 1'b0;
      end else begin
        dat_q[0] <= accept ? in_data[8*r +: 8] : 8'h00;
        act_q[0] <= accept;
        for (int s = 1; s <= r; s++) begin
          dat_q[s] <= dat_q[s-1];
          act_q[s] <= act_q[s-1];
        end
        out_dat_q <= dat_q[r];
        out_act_q <= act_q[r];
      end
    end

    assign data_out[8*r +: 8] = out_dat_q;
    assign active_out[r]      = out_act_q;
  end

endmodule

// File: tb/tb_sys_arr_feeder.sv
// Directed testbench for sys_arr_feeder (NUM_ROWS=2, ROW_WIDTH=2, LEN_W=8).
// Each cycle drives inputs, steps one clock edge, then compares outputs
// against hand-computed values just after the edge.

module tb_sys_arr_feeder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  vec_len;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [15:0] data_out;
  logic [1:0]  active_out;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  sys_arr_feeder #(
    .NUM_ROWS (2),
    .ROW_WIDTH(2),
    .LEN_W    (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .vec_len   (vec_len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .active_out(active_out),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, step one rising edge, check all outputs.
  task automatic cyc(input string tag,
                     input logic st, input logic [7:0] len,
                     input logic v, input logic [15:0] d,
                     input logic [15:0] e_d, input logic [1:0] e_a,
                     input logic e_busy, input logic e_done, input logic e_rdy);
    start    = st;
    vec_len  = len;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    check({tag, ".data"},  32'(data_out),   32'(e_d));
    check({tag, ".act"},   32'(active_out), 32'(e_a));
    check({tag, ".busy"},  32'(busy),       32'(e_busy));
    check({tag, ".done"},  32'(done),       32'(e_done));
    check({tag, ".ready"}, 32'(in_ready),   32'(e_rdy));
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    vec_len  = '0;
    in_valid = 1'b0;
    in_data  = '0;
    #12;
    check("rst.data",  32'(data_out),   32'h0);
    check("rst.act",   32'(active_out), 32'h0);
    check("rst.busy",  32'(busy),       32'h0);
    check("rst.done",  32'(done),       32'h0);
    check("rst.ready", 32'(in_ready),   32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic tile, vec_len=3, beats {r1,r0} = {-1,1},{-2,2},{-3,3}
    cyc("t1e0", 1, 8'd3, 0, 16'h0000, 16'h0000, 2'b00, 1, 0, 1);
    cyc("t1e1", 0, 8'd0, 1, 16'hFF01, 16'h0000, 2'b00, 1, 0, 1);
    cyc("t1e2", 0, 8'd0, 1, 16'hFE02, 16'h0001, 2'b01, 1, 0, 1);
    cyc("t1e3", 0, 8'd0, 1, 16'hFD03, 16'hFF02, 2'b11, 1, 0, 0);
    cyc("t1e4", 0, 8'd0, 0, 16'h0000, 16'hFE03, 2'b11, 1, 0, 0);
    cyc("t1e5", 0, 8'd0, 0, 16'h0000, 16'hFD00, 2'b10, 1, 0, 0);
    cyc("t1e6", 0, 8'd0, 0, 16'h0000, 16'h0000, 2'b00, 0, 1, 0);
    cyc("t1e7", 0, 8'd0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, 0);

    // Bubble between beat 1 and beat 2
    cyc("t2e0", 1, 8'd3, 0, 16'h0000, 16'h0000, 2'b00, 1, 0, 1);
    cyc("t2e1", 0, 8'd0, 1, 16'hFF01, 16'h0000, 2'b00, 1, 0, 1);
    cyc("t2e2", 0, 8'd0, 0, 16'h0000, 16'h0001, 2'b01, 1, 0, 1);
    cyc("t2e3", 0, 8'd0, 1, 16'hFE02, 16'hFF00, 2'b10, 1, 0, 1);
    cyc("t2e4", 0, 8'd0, 1, 16'hFD03, 16'h0002, 2'b01, 1, 0, 0);
    cyc("t2e5", 0, 8'd0, 0, 16'h0000, 16'hFE03, 2'b11, 1, 0, 0);
    cyc("t2e6", 0, 8'd0, 0, 16'h0000, 16'hFD00, 2'b10, 1, 0, 0);
    cyc("t2e7", 0, 8'd0, 0, 16'h0000, 16'h0000, 2'b00, 0, 1, 0);
    cyc("t2e8", 0, 8'd0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, 0);

    // Zero-length tile; in_valid offered but never accepted
    cyc("t3e0", 1, 8'd0, 1, 16'h1234, 16'h0000, 2'b00, 0, 1, 0);
    cyc("t3e1", 0, 8'd0, 1, 16'h1234, 16'h0000, 2'b00, 0, 0, 0);
    cyc("t3e2", 0, 8'd0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, 0);

    // Ignored start in STREAM/DRAIN, extreme element values, beat offered in DRAIN
    cyc("t4e0", 1, 8'd2, 0, 16'h0000, 16'h0000, 2'b00, 1, 0, 1);
    cyc("t4e1", 1, 8'd5, 1, 16'h807F, 16'h0000, 2'b00, 1, 0, 1);
    cyc("t4e2", 1, 8'd5, 1, 16'h7F80, 16'h007F, 2'b01, 1, 0, 0);
    cyc("t4e3", 1, 8'd5, 1, 16'h5555, 16'h8080, 2'b11, 1, 0, 0);
    cyc("t4e4", 1, 8'd5, 0, 16'h0000, 16'h7F00, 2'b10, 1, 0, 0);
    cyc("t4e5", 0, 8'd0, 0, 16'h0000, 16'h0000, 2'b00, 0, 1, 0);
    cyc("t4e6", 0, 8'd0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, 0);

    // Back-to-back tiles: second start in the done cycle
    cyc("t5e0", 1, 8'd1, 0, 16'h0000, 16'h0000, 2'b00, 1, 0, 1);
    cyc("t5e1", 0, 8'd0, 1, 16'h2211, 16'h0000, 2'b00, 1, 0, 0);
    cyc("t5e2", 0, 8'd0, 0, 16'h0000, 16'h0011, 2'b01, 1, 0, 0);
    cyc("t5e3", 0, 8'd0, 0, 16'h0000, 16'h2200, 2'b10, 1, 0, 0);
    cyc("t5e4", 0, 8'd0, 0, 16'h0000, 16'h0000, 2'b00, 0, 1, 0);
    cyc("t5e5", 1, 8'd1, 0, 16'h0000, 16'h0000, 2'b00, 1, 0, 1);
    cyc("t5e6", 0, 8'd0, 1, 16'h4433, 16'h0000, 2'b00, 1, 0, 0);
    cyc("t5e7", 0, 8'd0, 0, 16'h0000, 16'h0033, 2'b01, 1, 0, 0);
    cyc("t5e8", 0, 8'd0, 0, 16'h0000, 16'h4400, 2'b10, 1, 0, 0);
    cyc("t5e9", 0, 8'd0, 0, 16'h0000, 16'h0000, 2'b00, 0, 1, 0);
    cyc("t5e10", 0, 8'd0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, 0);

    // Asynchronous reset mid-STREAM with a non-empty pipeline
    cyc("t6e0", 1, 8'd3, 0, 16'h0000, 16'h0000, 2'b00, 1, 0, 1);
    cyc("t6e1", 0, 8'd0, 1, 16'hFF01, 16'h0000, 2'b00, 1, 0, 1);
    cyc("t6e2", 0, 8'd0, 1, 16'hFE02, 16'h0001, 2'b01, 1, 0, 1);
    rst_n = 1'b0;
    #2;
    check("t6rst.data",  32'(data_out),   32'h0);
    check("t6rst.act",   32'(active_out), 32'h0);
    check("t6rst.busy",  32'(busy),       32'h0);
    check("t6rst.done",  32'(done),       32'h0);
    check("t6rst.ready", 32'(in_ready),   32'h0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    // No flush after reset: pipeline stays empty and the feeder stays idle
    cyc("t6e3", 0, 8'd0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, 0);
    cyc("t6e4", 0, 8'd0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
